// File: rtl/nonce_result_checker_if.sv
// Handshake bundle between the nonce result checker, the SHA lane array,
// the nonce generator and the host control logic.
interface nonce_result_checker_if #(
    parameter int LANES  = 3,
    parameter int HASH_W = 256
);
    logic                     start;
    logic [HASH_W-1:0]        target;
    logic [LANES-1:0]         res_valid;
    logic [LANES*HASH_W-1:0]  res_hash;
    logic [LANES*32-1:0]      res_nonce;
    logic                     lanes_idle;
    logic                     gen_overflow;
    logic                     ack;
    logic                     gen_enable;
    logic                     gen_restart;
    logic                     busy;
    logic                     found;
    logic                     exhausted;
    logic [31:0]              golden_nonce;
    logic [31:0]              results_checked;

    modport master (
        output start, target, res_valid, res_hash, res_nonce,
               lanes_idle, gen_overflow, ack,
        input  gen_enable, gen_restart, busy, found, exhausted,
               golden_nonce, results_checked
    );

    modport slave (
        input  start, target, res_valid, res_hash, res_nonce,
               lanes_idle, gen_overflow, ack,
        output gen_enable, gen_restart, busy, found, exhausted,
               golden_nonce, results_checked
    );
endinterface

// File: rtl/nonce_result_checker.sv
// Collects per-lane SHA results, captures the first hash below target as the
// golden nonce, and reports exhaustion once the generator overflowed and drained.
module nonce_result_checker #(
    parameter int LANES  = 3,
    parameter int HASH_W = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    nonce_result_checker_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SEARCH, FOUND, EXHAUSTED} state_t;

    state_t             state;
    logic [HASH_W-1:0]  target_q;
    logic               ovf_seen;
    logic               gen_restart_q;
    logic               found_q;
    logic               exhausted_q;
    logic [31:0]        golden_q;
    logic [31:0]        checked_q;

    logic               any_hit_p0;
    logic [31:0]        hit_nonce_p0;
    logic [31:0]        valid_cnt_p0;
    logic               vld_p1;
    logic               stage_hit_p1;
    logic [31:0]        stage_nonce_p1;

    function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + 32'(v[i]);
        return n;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [31:0] inc);
        logic [32:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Stage p0: per-lane compare; descending scan so the lowest hitting lane wins
    always_comb begin
        any_hit_p0   = 1'b0;
        hit_nonce_p0 = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (bus.res_valid[i] && (bus.res_hash[i*HASH_W +: HASH_W] < target_q)) begin
                any_hit_p0   = 1'b1;
                hit_nonce_p0 = bus.res_nonce[i*32 +: 32];
            end
        end
        valid_cnt_p0 = popcount(bus.res_valid);
    end

    // Stage p1: registered compare result plus job FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            target_q       <= '0;
            ovf_seen       <= 1'b0;
            gen_restart_q  <= 1'b0;
            found_q        <= 1'b0;
            exhausted_q    <= 1'b0;
            golden_q       <= '0;
            checked_q      <= '0;
            vld_p1         <= 1'b0;
            stage_hit_p1   <= 1'b0;
            stage_nonce_p1 <= '0;
        end else begin
            gen_restart_q <= 1'b0;
            case (state)
                IDLE, FOUND, EXHAUSTED: begin
                    if (bus.start) begin
                        target_q       <= bus.target;
                        gen_restart_q  <= 1'b1;
                        checked_q      <= '0;
                        ovf_seen       <= 1'b0;
                        vld_p1         <= 1'b0;
                        stage_hit_p1   <= 1'b0;
                        stage_nonce_p1 <= '0;
                        found_q        <= 1'b0;
                        exhausted_q    <= 1'b0;
                        state          <= SEARCH;
                    end else if (bus.ack && state != IDLE) begin
                        found_q     <= 1'b0;
                        exhausted_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                SEARCH: begin
                    vld_p1         <= |bus.res_valid;
                    stage_hit_p1   <= any_hit_p0;
                    stage_nonce_p1 <= hit_nonce_p0;
                    checked_q      <= sat_add32(checked_q, valid_cnt_p0);
                    if (bus.gen_overflow) ovf_seen <= 1'b1;
                    // A pending win outranks exhaustion
                    if (vld_p1 && stage_hit_p1) begin
                        golden_q <= stage_nonce_p1;
                        found_q  <= 1'b1;
                        state    <= FOUND;
                    end else if (ovf_seen && bus.lanes_idle && !(|bus.res_valid) && !vld_p1) begin
                        exhausted_q <= 1'b1;
                        state       <= EXHAUSTED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy            = (state == SEARCH);
    assign bus.gen_enable      = (state == SEARCH) & ~ovf_seen & ~bus.gen_overflow & ~gen_restart_q;
    assign bus.gen_restart     = gen_restart_q;
    assign bus.found           = found_q;
    assign bus.exhausted       = exhausted_q;
    assign bus.golden_nonce    = golden_q;
    assign bus.results_checked = checked_q;

endmodule

// File: tb/tb_nonce_result_checker.sv
// Scoreboard bench for nonce_result_checker: job outcomes are queued when
// lane results are driven and retired when found/exhausted rises.
module tb_nonce_result_checker;

    localparam int LANES  = 3;
    localparam int HASH_W = 256;

    typedef struct {
        bit          win;
        logic [31:0] nonce;
    } outcome_t;

    logic clk;
    logic rst;

    nonce_result_checker_if #(.LANES(LANES), .HASH_W(HASH_W)) bus ();

    nonce_result_checker #(.LANES(LANES), .HASH_W(HASH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_errors = 0;
    outcome_t         sb_q[$];
    logic [255:0]     model_target;
    bit               model_search;
    bit               model_won;
    logic [31:0]      exp_cnt;

    localparam logic [255:0] TGT  = {32'h0000_FFFF, 224'd0};
    localparam logic [255:0] HIT  = {32'h0000_0001, 224'd0};
    localparam logic [255:0] MISS = {32'h0001_0000, 224'd0};
    localparam logic [255:0] MAXH = {256{1'b1}};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start    = 1'b1;
        bus.target   = TGT;
        model_target = TGT;
        model_search = 1'b1;
        model_won    = 1'b0;
        exp_cnt      = '0;
        tick();
        bus.start = 1'b0;
    endtask

    // Drive one cycle of lane results and update the reference model
    task automatic present(input logic [2:0] v,
                           input logic [255:0] h0, input logic [255:0] h1, input logic [255:0] h2,
                           input logic [31:0] n0, input logic [31:0] n1, input logic [31:0] n2);
        logic [255:0] hh[3];
        logic [31:0]  nn[3];
        outcome_t     e;
        hh = '{h0, h1, h2};
        nn = '{n0, n1, n2};
        bus.res_valid = v;
        bus.res_hash  = {h2, h1, h0};
        bus.res_nonce = {n2, n1, n0};
        if (model_search) begin
            exp_cnt = exp_cnt + 32'($countones(v));
            if (!model_won) begin
                for (int i = 0; i < LANES; i++) begin
                    if (!model_won && v[i] && (hh[i] < model_target)) begin
                        e.win     = 1'b1;
                        e.nonce   = nn[i];
                        model_won = 1'b1;
                        sb_q.push_back(e);
                    end
                end
            end
        end
        tick();
        bus.res_valid = '0;
    endtask

    task automatic expect_exhaust();
        outcome_t e;
        if (!model_won) begin
            e.win   = 1'b0;
            e.nonce = '0;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_outcome();
        outcome_t e;
        int n;
        n = 0;
        while (!(bus.found || bus.exhausted) && n < 20) begin
            tick();
            n++;
        end
        chk("outcome_seen", 32'(bus.found | bus.exhausted), 32'd1);
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("out_found", 32'(bus.found), 32'(e.win));
            chk("out_exhausted", 32'(bus.exhausted), 32'(!e.win));
            if (e.win) chk("out_golden", bus.golden_nonce, e.nonce);
        end
        model_search = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.target       = '0;
        bus.res_valid    = '0;
        bus.res_hash     = '0;
        bus.res_nonce    = '0;
        bus.lanes_idle   = 1'b1;
        bus.gen_overflow = 1'b0;
        bus.ack          = 1'b0;
        model_target     = '0;
        model_search     = 1'b0;
        model_won        = 1'b0;
        exp_cnt          = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_found", 32'(bus.found), 32'd0);
        chk("rst_exhausted", 32'(bus.exhausted), 32'd0);
        chk("rst_gen_enable", 32'(bus.gen_enable), 32'd0);
        chk("rst_gen_restart", 32'(bus.gen_restart), 32'd0);
        chk("rst_golden", bus.golden_nonce, 32'd0);
        chk("rst_checked", bus.results_checked, 32'd0);
        rst = 1'b0;
        tick();

        // Job 1: single winner on lane 1
        do_start();
        chk("j1_restart", 32'(bus.gen_restart), 32'd1);
        chk("j1_busy", 32'(bus.busy), 32'd1);
        chk("j1_gen_en_restart", 32'(bus.gen_enable), 32'd0);
        chk("j1_checked0", bus.results_checked, 32'd0);
        tick();
        chk("j1_restart_once", 32'(bus.gen_restart), 32'd0);
        chk("j1_gen_en", 32'(bus.gen_enable), 32'd1);
        present(3'b111, MISS, HIT, MAXH, 32'h3, 32'h4, 32'h5);
        chk("j1_found_lat1", 32'(bus.found), 32'd0);
        chk("j1_checked", bus.results_checked, exp_cnt);
        tick();
        chk("j1_found_lat2", 32'(bus.found), 32'd1);
        chk("j1_gen_en_off", 32'(bus.gen_enable), 32'd0);
        chk("j1_busy_off", 32'(bus.busy), 32'd0);
        wait_outcome();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("j1_ack_found", 32'(bus.found), 32'd0);
        chk("j1_ack_golden", bus.golden_nonce, 32'h4);
        present(3'b111, HIT, HIT, HIT, 32'h1, 32'h2, 32'h3);
        chk("idle_drop_checked", bus.results_checked, 32'd3);
        chk("idle_drop_busy", 32'(bus.busy), 32'd0);

        // Job 2: simultaneous winners, then later hits ignored
        do_start();
        tick();
        present(3'b111, HIT, MISS, HIT, 32'h9, 32'hA, 32'hB);
        present(3'b010, MISS, HIT, MISS, 32'h0, 32'h20, 32'h0);
        chk("j2_found", 32'(bus.found), 32'd1);
        chk("j2_golden", bus.golden_nonce, 32'h9);
        wait_outcome();
        present(3'b001, HIT, MISS, MISS, 32'h30, 32'h0, 32'h0);
        chk("j2_golden_kept", bus.golden_nonce, 32'h9);
        chk("j2_checked", bus.results_checked, exp_cnt);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;

        // Job 3: exhaustion after overflow and drain
        do_start();
        tick();
        bus.gen_overflow = 1'b1;
        bus.lanes_idle   = 1'b0;
        #1;
        chk("j3_gen_en_ovf", 32'(bus.gen_enable), 32'd0);
        tick();
        bus.gen_overflow = 1'b0;
        #1;
        chk("j3_gen_en_ovf_seen", 32'(bus.gen_enable), 32'd0);
        tick();
        chk("j3_not_idle", 32'(bus.exhausted), 32'd0);
        bus.lanes_idle = 1'b1;
        expect_exhaust();
        present(3'b100, MISS, MISS, MAXH, 32'h0, 32'h0, 32'h50);
        chk("j3_exh_lat1", 32'(bus.exhausted), 32'd0);
        tick();
        chk("j3_exh_lat2", 32'(bus.exhausted), 32'd0);
        tick();
        chk("j3_exh", 32'(bus.exhausted), 32'd1);
        chk("j3_found", 32'(bus.found), 32'd0);
        chk("j3_gen_en", 32'(bus.gen_enable), 32'd0);
        wait_outcome();

        // start beats ack in EXHAUSTED
        bus.ack = 1'b1;
        do_start();
        bus.ack = 1'b0;
        chk("j4_start_wins_busy", 32'(bus.busy), 32'd1);
        chk("j4_start_wins_restart", 32'(bus.gen_restart), 32'd1);
        chk("j4_start_wins_exh", 32'(bus.exhausted), 32'd0);

        // Job 4: hit arrives as lanes go idle after overflow
        tick();
        bus.gen_overflow = 1'b1;
        bus.lanes_idle   = 1'b0;
        tick();
        bus.lanes_idle = 1'b1;
        present(3'b001, HIT, MISS, MISS, 32'h77, 32'h0, 32'h0);
        tick();
        chk("j4_found", 32'(bus.found), 32'd1);
        chk("j4_not_exh", 32'(bus.exhausted), 32'd0);
        wait_outcome();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("j4_ack_found", 32'(bus.found), 32'd0);
        chk("j4_ack_busy", 32'(bus.busy), 32'd0);
        chk("j4_golden_kept", bus.golden_nonce, 32'h77);
        bus.gen_overflow = 1'b0;

        // Job 5: start ignored in SEARCH, then asynchronous reset
        do_start();
        tick();
        present(3'b001, MISS, MISS, MISS, 32'h1, 32'h0, 32'h0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("j5_no_restart", 32'(bus.gen_restart), 32'd0);
        chk("j5_checked_kept", bus.results_checked, exp_cnt);
        chk("j5_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_gen_en", 32'(bus.gen_enable), 32'd0);
        chk("arst_golden", bus.golden_nonce, 32'd0);
        chk("arst_checked", bus.results_checked, 32'd0);
        tick();
        rst = 1'b0;
        model_search = 1'b0;
        tick();
        chk("post_rst_restart", 32'(bus.gen_restart), 32'd0);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nonce_result_checker.md
Name: nonce_result_checker

Overview:
- Consumer end of the nonce stream: drives the nonce generator's enable/restart and collects hash results from LANES parallel SHA lanes.
- Compares each returned hash against the job target and captures the first winning (golden) nonce.
- Reports exhaustion once the generator has overflowed and all lanes have drained.
- Sits between the parallel SHA array and the host/control interface.

Parameters:
- LANES, 3, number of parallel SHA lanes; matches the generator's skip value.
- HASH_W, 256, hash and target width in bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock, asynchronous and active-high.
- start  input  1  begin a new job; latches target.
- target  input  HASH_W  difficulty target; a hash wins when hash < target (unsigned).
- res_valid  input  LANES  per-lane result-valid strobe, one cycle per result.
- res_hash  input  LANES*HASH_W  per-lane hash; lane i occupies bits [i*HASH_W +: HASH_W].
- res_nonce  input  LANES*32  per-lane nonce for that hash; lane i occupies bits [i*32 +: 32].
- lanes_idle  input  1  all SHA lanes empty, with no work in flight.
- gen_overflow  input  1  the generator's nonce is at its maximum value.
- ack  input  1  host acknowledge of found or exhausted.
- gen_enable  output  1  advance the nonce generator.
- gen_restart  output  1  one-cycle restart pulse to the generator.
- busy  output  1  a job is in progress (SEARCH).
- found  output  1  golden nonce valid.
- exhausted  output  1  nonce space finished with no win.
- golden_nonce  output  32  winning nonce.
- results_checked  output  32  count of lane results examined in the current job.

Behaviour:
- Reset: state IDLE. All outputs 0, including golden_nonce and results_checked. target_q, stage register and ovf_seen are cleared.
- States: IDLE, SEARCH, FOUND, EXHAUSTED.
- Starting a job:
  - start is accepted in IDLE, FOUND and EXHAUSTED.
  - On acceptance: latch target into target_q, pulse gen_restart for exactly one cycle, clear results_checked, ovf_seen, the stage register and found/exhausted, then enter SEARCH.
  - start in SEARCH is ignored.
- Compare stage:
  - Each cycle in SEARCH, every lane with res_valid computes hit_i = res_hash_i < target_q.
  - Registered at the next edge: stage_hit (any hit), stage_nonce (nonce of the lowest-index hitting lane), stage_v.
  - Results presented outside SEARCH are dropped and not counted.
- Win:
  - In SEARCH with stage_v & stage_hit: golden_nonce <= stage_nonce, state -> FOUND.
  - found is high from the second rising edge after the res_valid cycle (2-cycle latency).
  - Multiple simultaneous winners: the lowest lane index wins.
  - Later results and stage contents are ignored; the first win is kept.
- Generator control:
  - gen_enable = (state==SEARCH) & ~ovf_seen & ~gen_overflow & ~gen_restart.
  - ovf_seen is set in SEARCH when gen_overflow is high.
- Exhaustion: in SEARCH, when ovf_seen & lanes_idle & ~|res_valid & ~stage_v all hold, state -> EXHAUSTED.
  - A win pending in the stage register always takes priority over exhaustion.
- Counting:
  - results_checked += popcount(res_valid) each SEARCH cycle.
  - It saturates at 32'hFFFF_FFFF and holds its value outside SEARCH.
- busy = (state==SEARCH).
- Acknowledge:
  - ack in FOUND or EXHAUSTED returns to IDLE and clears found/exhausted; golden_nonce is held until the next start.
  - ack in other states is ignored.
  - If ack and start are both high in FOUND or EXHAUSTED, start wins and the block enters SEARCH.
- Reset mid-job: immediate return to the reset state, with no gen_restart pulse.

Test Plan:
- Reset then start with target=256'h0000_FFFF<<224: gen_restart pulses exactly one cycle, busy=1, gen_enable=1 from the next cycle, results_checked=0.
- Lane1 returns hash=256'h0000_0001..., nonce=32'h0000_0004; other lanes return hashes ≥ target; all res_valid in cycle N -> found=1 at cycle N+2, golden_nonce=32'h4, gen_enable=0, results_checked=3.
- Lanes 0 and 2 both hit in the same cycle with nonces 32'h9 and 32'hB -> golden_nonce=32'h9. A hit on the following cycle with nonce 32'h20 -> golden_nonce stays 32'h9.
- Exhaustion: gen_overflow=1 while one result is still in flight (lanes_idle=0), then a non-winning result arrives and lanes_idle=1 -> exhausted=1 one cycle after the stage drains, found=0, gen_enable=0 from the ovf cycle.
- Hit arrives in the same cycle lanes_idle rises after overflow -> FOUND, not EXHAUSTED. Then ack -> IDLE, found=0, golden_nonce retained.
- rst asserted mid-SEARCH -> all outputs 0 asynchronously. start asserted during SEARCH -> no gen_restart pulse and results_checked not cleared.
